dds_multi_voice: RTL

Time-multiplexed multi-voice DDS oscillator with a mixer. Each voice is configurable as square (programmable duty), sawtooth, triangle or off, and has its own 4-bit volume. On every `sample_tick` the block steps through all voices, one per clock, and accumulates them. It then emits one saturated signed 16-bit mixed sample. It sits between the tracker sequencer (which owns the config port) and the audio output / DAC serializer.

---
 rtl/dds_pkg.sv | 28 ++
 rtl/dds_voice_shaper.sv | 39 +++
 rtl/dds_multi_voice.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared types and widths for the multi-voice DDS oscillator and its shaper.
package dds_pkg;

  localparam int SAMPLE_W = 16;
  localparam int VOL_W    = 4;
  localparam int DUTY_W   = 8;

  typedef enum logic [1:0] {
    WAVE_OFF    = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_SAW    = 2'd2,
    WAVE_TRI    = 2'd3
  } wave_mode_e;

  typedef enum logic [1:0] {
    SEL_FREQ      = 2'd0,
    SEL_DUTY      = 2'd1,
    SEL_CTRL      = 2'd2,
    SEL_PHASE_RST = 2'd3
  } cfg_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dds_state_e;

endpackage

// File: rtl/dds_voice_shaper.sv
// Combinational waveform generator and volume scaler for one voice.
// It is shared by all voices of the time-multiplexed datapath.
module dds_voice_shaper
  import dds_pkg::*;
(
  input  logic [16:0]                i_phase_hi,
  input  wave_mode_e                 i_mode,
  input  logic [DUTY_W-1:0]          i_duty,
  input  logic [VOL_W-1:0]           i_vol,
  output logic signed [SAMPLE_W-1:0] o_scaled
);

  logic [7:0]                 w_t;
  logic [15:0]                w_s;
  logic [15:0]                w_u;
  logic signed [SAMPLE_W-1:0] w_wave;
  logic [VOL_W:0]             w_gain;
  logic signed [20:0]         w_prod;

  assign w_t = i_phase_hi[16:9];
  assign w_s = i_phase_hi[16:1];
  assign w_u = i_phase_hi[15:0];

  // In both triangle halves, U - 32768 reduces to U ^ 0x8000 and 32767 - U reduces to its complement.
  always_comb begin
    w_wave = '0;
    case (i_mode)
      WAVE_SQUARE: w_wave = (w_t < i_duty) ? 16'sh7FFF : 16'sh8000;
      WAVE_SAW:    w_wave = w_s ^ 16'h8000;
      WAVE_TRI:    w_wave = i_phase_hi[16] ? ~(w_u ^ 16'h8000) : (w_u ^ 16'h8000);
      default:     w_wave = '0;
    endcase
  end

  assign w_gain   = {1'b0, i_vol} + 5'd1;
  assign w_prod   = 21'(w_wave) * $signed({16'b0, w_gain});
  assign o_scaled = SAMPLE_W'(w_prod >>> 4);

endmodule

// File: rtl/dds_multi_voice.sv
// Time-multiplexed DDS voices mixed into one saturated 16-bit sample per tick.
// On each clock, one voice is shaped, accumulated and phase-advanced.
module dds_multi_voice
  import dds_pkg::*;
#(
  parameter  int PHASE_WIDTH = 32,
  parameter  int NUM_CH      = 4,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst_active_low,
  input  logic                       sample_tick,
  input  logic                       cfg_we,
  input  logic [CH_W-1:0]            cfg_ch,
  input  logic [1:0]                 cfg_sel,
  input  logic [PHASE_WIDTH-1:0]     cfg_wdata,
  output logic                       busy,
  output logic signed [SAMPLE_W-1:0] mix_out,
  output logic                       mix_valid
);

  localparam int ACC_W = SAMPLE_W + CH_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-32768);

  logic [PHASE_WIDTH-1:0] r_phase [NUM_CH];
  logic [PHASE_WIDTH-1:0] r_freq  [NUM_CH];
  logic [DUTY_W-1:0]      r_duty  [NUM_CH];
  wave_mode_e             r_mode  [NUM_CH];
  logic [VOL_W-1:0]       r_vol   [NUM_CH];

  dds_state_e                 r_state;
  dds_state_e                 w_state_next;
  logic [CH_W-1:0]            r_idx;
  logic [CH_W-1:0]            w_idx_next;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [ACC_W-1:0]    w_acc_next;
  logic                       w_load_mix;
  logic signed [SAMPLE_W-1:0] w_mix_sat;
  logic signed [SAMPLE_W-1:0] w_scaled;
  logic                       r_busy;
  logic signed [SAMPLE_W-1:0] r_mix_out;
  logic                       r_mix_valid;

  dds_voice_shaper u_shaper (
    .i_phase_hi (r_phase[r_idx][PHASE_WIDTH-1 -: 17]),
    .i_mode     (r_mode[r_idx]),
    .i_duty     (r_duty[r_idx]),
    .i_vol      (r_vol[r_idx]),
    .o_scaled   (w_scaled)
  );

  // The last RUN cycle loads the clamped sum, so the DONE cycle already presents it.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_acc_next   = r_acc;
    w_load_mix   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sample_tick) begin
          w_state_next = ST_RUN;
          w_idx_next   = '0;
          w_acc_next   = '0;
        end
      end
      ST_RUN: begin
        w_acc_next = r_acc + ACC_W'(w_scaled);
        w_idx_next = r_idx + CH_W'(1);
        if (r_idx == CH_W'(NUM_CH - 1)) begin
          w_state_next = ST_DONE;
          w_idx_next   = '0;
          w_load_mix   = 1'b1;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    if (w_acc_next > ACC_MAX) begin
      w_mix_sat = 16'sh7FFF;
    end else if (w_acc_next < ACC_MIN) begin
      w_mix_sat = 16'sh8000;
    end else begin
      w_mix_sat = SAMPLE_W'(w_acc_next);
    end
  end

  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_busy      <= 1'b0;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_acc       <= w_acc_next;
      r_busy      <= (w_state_next != ST_IDLE);
      r_mix_valid <= w_load_mix;
      if (w_load_mix) begin
        r_mix_out <= w_mix_sat;
      end
    end
  end

  // The config write is placed after the advance, so PHASE_RST beats a same-cycle advance.
  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      for (int j = 0; j < NUM_CH; j++) begin
        r_phase[j] <= '0;
        r_freq[j]  <= '0;
        r_duty[j]  <= '0;
        r_mode[j]  <= WAVE_OFF;
        r_vol[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (r_state == ST_RUN && r_idx == CH_W'(j)) begin
          r_phase[j] <= r_phase[j] + r_freq[j];
        end
        if (cfg_we && cfg_ch == CH_W'(j)) begin
          case (cfg_sel_e'(cfg_sel))
            SEL_FREQ: r_freq[j] <= cfg_wdata;
            SEL_DUTY: r_duty[j] <= cfg_wdata[DUTY_W-1:0];
            SEL_CTRL: begin
              r_mode[j] <= wave_mode_e'(cfg_wdata[1:0]);
              r_vol[j]  <= cfg_wdata[4 +: VOL_W];
            end
            SEL_PHASE_RST: r_phase[j] <= '0;
            default: ;
          endcase
        end
      end
    end
  end

  assign busy      = r_busy;
  assign mix_out   = r_mix_out;
  assign mix_valid = r_mix_valid;

endmodule
